// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared constants for the HTIF PCR arbiter: state encodings, requester count
// and default widths of the CSR file's HTIF PCR port.
package vscale_htif_pcr_arbiter_pkg;

    localparam int CSR_ADDR_WIDTH      = 12;
    localparam int HTIF_PCR_WIDTH      = 64;
    localparam int N_PCR_REQ           = 2;
    localparam int PCR_ARB_STATE_WIDTH = 2;

    typedef enum logic [PCR_ARB_STATE_WIDTH-1:0] {
        PCR_ARB_IDLE = 2'd0,
        PCR_ARB_REQ  = 2'd1,
        PCR_ARB_RESP = 2'd2
    } pcr_arb_state_e;

endpackage

// File: rtl/vscale_htif_pcr_arbiter_rr_grant2.sv
// vscale_rr_grant2: combinational 2-way one-hot grant.
// With rr_en set a tie goes to the port that was not served last; otherwise
// port 0 always wins a tie.
module vscale_rr_grant2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] grant
);

    // Pick at most one requester.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_en && !last) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// vscale_htif_pcr_arbiter: shares the CSR file's single HTIF PCR port between
// two host requesters, one transaction in flight at a time.
// Build option: define VSCALE_PCR_ARB_RR_EN for round-robin tie breaking;
// without it port 0 has fixed priority.
module vscale_htif_pcr_arbiter
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_WIDTH,
    parameter int DATA_W = HTIF_PCR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PCR_REQ-1:0]       s_req_valid,
    output logic [N_PCR_REQ-1:0]       s_req_ready,
    input  logic [N_PCR_REQ-1:0]       s_req_rw,
    input  logic [N_PCR_REQ*ADDR_W-1:0] s_req_addr,
    input  logic [N_PCR_REQ*DATA_W-1:0] s_req_data,
    output logic [N_PCR_REQ-1:0]       s_resp_valid,
    input  logic [N_PCR_REQ-1:0]       s_resp_ready,
    output logic [DATA_W-1:0]          s_resp_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic                       m_req_rw,
    output logic [ADDR_W-1:0]          m_req_addr,
    output logic [DATA_W-1:0]          m_req_data,
    input  logic                       m_resp_valid,
    output logic                       m_resp_ready,
    input  logic [DATA_W-1:0]          m_resp_data
);

    pcr_arb_state_e    state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        grant;
    logic              rr_en;

`ifdef VSCALE_PCR_ARB_RR_EN
    assign rr_en = 1'b1;
`else
    assign rr_en = 1'b0;
`endif

    vscale_rr_grant2 u_grant (
        .valid (s_req_valid),
        .last  (last_q),
        .rr_en (rr_en),
        .grant (grant)
    );

    // State and latched request registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PCR_ARB_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and handshake outputs. s_req_ready is masked by reset
    // so every valid/ready output reads 0 while reset is held.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        s_req_ready  = 2'b00;
        s_resp_valid = 2'b00;
        s_resp_data  = '0;
        m_req_valid  = 1'b0;
        m_resp_ready = 1'b0;
        case (state_q)
            PCR_ARB_IDLE: begin
                if (!reset && (grant != 2'b00)) begin
                    s_req_ready = grant;
                    owner_d     = grant[1];
                    rw_d        = grant[1] ? s_req_rw[1] : s_req_rw[0];
                    addr_d      = grant[1] ? s_req_addr[ADDR_W +: ADDR_W]
                                           : s_req_addr[0 +: ADDR_W];
                    data_d      = grant[1] ? s_req_data[DATA_W +: DATA_W]
                                           : s_req_data[0 +: DATA_W];
                    state_d     = PCR_ARB_REQ;
                end
            end
            PCR_ARB_REQ: begin
                m_req_valid = 1'b1;
                if (m_req_ready) begin
                    state_d = PCR_ARB_RESP;
                end
            end
            PCR_ARB_RESP: begin
                s_resp_valid[owner_q] = m_resp_valid;
                s_resp_data           = m_resp_data;
                m_resp_ready          = s_resp_ready[owner_q];
                if (m_resp_valid && s_resp_ready[owner_q]) begin
                    state_d = PCR_ARB_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = PCR_ARB_IDLE;
        endcase
    end

    assign m_req_rw   = rw_q;
    assign m_req_addr = addr_q;
    assign m_req_data = data_q;

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Directed self-checking bench for vscale_htif_pcr_arbiter.
module tb_vscale_htif_pcr_arbiter;
    import vscale_htif_pcr_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    s_req_valid, s_req_ready, s_req_rw;
    logic [2*AW-1:0] s_req_addr;
    logic [2*DW-1:0] s_req_data;
    logic [1:0]    s_resp_valid, s_resp_ready;
    logic [DW-1:0] s_resp_data;
    logic          m_req_valid, m_req_ready, m_req_rw;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_data;
    logic          m_resp_valid, m_resp_ready;
    logic [DW-1:0] m_resp_data;

    int checks = 0;
    int failures = 0;

    vscale_htif_pcr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
        .s_req_addr(s_req_addr), .s_req_data(s_req_data),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_data(s_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_rw(m_req_rw),
        .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_req_valid = 2'b00; s_req_rw = 2'b00; s_req_addr = '0; s_req_data = '0;
        s_resp_ready = 2'b11; m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Serve whatever request is granted; CSR model accepts immediately and
    // answers one cycle later. granted = 0 if nothing was granted in budget.
    task automatic run_txn(output logic [1:0] granted);
        granted = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (s_req_ready != 2'b00) begin
                granted = s_req_ready;
                break;
            end
            tick();
        end
        if (granted != 2'b00) begin
            m_req_ready = 1'b1;
            tick();
            tick();
            m_resp_valid = 1'b1;
            m_resp_data = 64'h77;
            tick();
            m_resp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_req_valid = 2'b11; s_req_rw = 2'b00; s_req_addr = '0; s_req_data = '0;
        s_resp_ready = 2'b11; m_req_ready = 1'b1; m_resp_valid = 1'b1; m_resp_data = 64'h1;
        tick();
        checks++;
        if ({s_req_ready, s_resp_valid, m_req_valid, m_resp_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_valid_ready got=%b want=000000",
                     {s_req_ready, s_resp_valid, m_req_valid, m_resp_ready});
        end
        checks++;
        if ({m_req_rw, m_req_addr, m_req_data, s_resp_data} !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h data=%h resp=%h want 0",
                     m_req_addr, m_req_data, s_resp_data);
        end
        checks++;
        if (dut.state_q !== PCR_ARB_IDLE || dut.last_q !== 1'b1 || dut.owner_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got state=%0d last=%b owner=%b want 0/1/0",
                     dut.state_q, dut.last_q, dut.owner_q);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        s_req_valid = 2'b01; s_req_rw = 2'b00; s_req_addr = {12'h000, 12'h780};
        m_req_ready = 1'b1;
        #1;
        checks++;
        if (s_req_ready !== 2'b01) begin
            failures++; $display("FAIL rd_accept got=%b want=01", s_req_ready);
        end
        tick();
        s_req_valid = 2'b00;
        checks++;
        if (m_req_valid !== 1'b1 || m_req_addr !== 12'h780 || m_req_rw !== 1'b0) begin
            failures++;
            $display("FAIL rd_mreq got v=%b a=%h rw=%b want 1/780/0", m_req_valid, m_req_addr, m_req_rw);
        end
        tick();
        m_resp_valid = 1'b1; m_resp_data = 64'h5;
        #1;
        checks++;
        if (s_resp_valid !== 2'b01 || s_resp_data !== 64'h5 || m_resp_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_resp got v=%b d=%h mr=%b want 01/5/1", s_resp_valid, s_resp_data, m_resp_ready);
        end
        tick();
        checks++;
        if (dut.state_q !== PCR_ARB_IDLE || s_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL rd_done got state=%0d v=%b want 0/00", dut.state_q, s_resp_valid);
        end
        m_resp_valid = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [1:0] g;
        logic [1:0] exp_g [4];
`ifdef VSCALE_PCR_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        s_req_valid = 2'b11;
        s_req_addr = {12'h111, 12'h222};
        #1;
        for (int i = 0; i < 4; i++) begin
            run_txn(g);
            checks++;
            if (g !== exp_g[i]) begin
                failures++;
                $display("FAIL sim_grant%0d got=%b want=%b", i, g, exp_g[i]);
            end
        end
        s_req_valid = 2'b00;
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        s_req_valid = 2'b10; s_req_rw = 2'b10;
        s_req_addr = {12'h781, 12'h000};
        s_req_data = {64'hABCD, 64'h0};
        m_req_ready = 1'b1;
        #1;
        checks++;
        if (s_req_ready !== 2'b10) begin
            failures++; $display("FAIL bp_accept got=%b want=10", s_req_ready);
        end
        tick();
        s_req_valid = 2'b00;
        checks++;
        if (m_req_rw !== 1'b1 || m_req_addr !== 12'h781 || m_req_data !== 64'hABCD) begin
            failures++;
            $display("FAIL bp_mreq got rw=%b a=%h d=%h want 1/781/abcd", m_req_rw, m_req_addr, m_req_data);
        end
        tick();
        m_resp_valid = 1'b1; m_resp_data = 64'h0;
        s_resp_ready = 2'b01;
        s_req_valid = 2'b01; s_req_rw = 2'b00; s_req_addr = {12'h000, 12'h055};
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (dut.state_q !== PCR_ARB_RESP || m_resp_ready !== 1'b0 ||
                s_resp_valid !== 2'b10 || s_req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold%0d got st=%0d mr=%b rv=%b sr=%b want 2/0/10/00",
                         i, dut.state_q, m_resp_ready, s_resp_valid, s_req_ready);
            end
            tick();
        end
        s_resp_ready = 2'b11;
        #1;
        checks++;
        if (m_resp_ready !== 1'b1 || s_req_ready !== 2'b00) begin
            failures++;
            $display("FAIL bp_release got mr=%b sr=%b want 1/00", m_resp_ready, s_req_ready);
        end
        tick();
        m_resp_valid = 1'b0;
        checks++;
        if (s_req_ready !== 2'b01) begin
            failures++; $display("FAIL bp_next_accept got=%b want=01", s_req_ready);
        end
        tick();
        s_req_valid = 2'b00;
        tick();
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0;
    endtask

    task automatic test_req_backpressure();
        do_reset();
        m_req_ready = 1'b0;
        s_req_valid = 2'b01; s_req_rw = 2'b01;
        s_req_addr = {12'h000, 12'h123};
        s_req_data = {64'h0, 64'h1111};
        tick();
        s_req_rw = 2'b00; s_req_addr = {12'h000, 12'h456}; s_req_data = {64'h0, 64'h2222};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_req_valid !== 1'b1 || m_req_rw !== 1'b1 || m_req_addr !== 12'h123 ||
                m_req_data !== 64'h1111 || s_req_ready !== 2'b00) begin
                failures++;
                $display("FAIL rq_hold%0d got v=%b rw=%b a=%h d=%h sr=%b want 1/1/123/1111/00",
                         i, m_req_valid, m_req_rw, m_req_addr, m_req_data, s_req_ready);
            end
            tick();
        end
        s_req_valid = 2'b00;
        m_req_ready = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== PCR_ARB_RESP || m_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rq_to_resp got st=%0d v=%b want 2/0", dut.state_q, m_req_valid);
        end
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        m_req_ready = 1'b1;
        s_req_valid = 2'b01; s_req_addr = {12'h000, 12'h0AA};
        tick();
        s_req_valid = 2'b10; s_req_addr = {12'h0BB, 12'h000};
        m_req_ready = 1'b0;
        checks++;
        if (s_req_ready !== 2'b00) begin
            failures++; $display("FAIL ar_pending got=%b want=00", s_req_ready);
        end
        m_req_ready = 1'b1;
        tick();
        m_resp_valid = 1'b1; m_resp_data = 64'hDEAD;
        #1;
        checks++;
        if (s_resp_valid !== 2'b01) begin
            failures++; $display("FAIL ar_pre got=%b want=01", s_resp_valid);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({s_req_ready, s_resp_valid, m_req_valid, m_resp_ready} !== 6'b0 ||
            s_resp_data !== '0 || m_req_addr !== '0 || dut.state_q !== PCR_ARB_IDLE) begin
            failures++;
            $display("FAIL ar_clear got sr=%b rv=%b mv=%b mr=%b rd=%h a=%h st=%0d want zeros",
                     s_req_ready, s_resp_valid, m_req_valid, m_resp_ready, s_resp_data,
                     m_req_addr, dut.state_q);
        end
        m_resp_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (s_req_ready !== 2'b10) begin
            failures++; $display("FAIL ar_first_accept got=%b want=10", s_req_ready);
        end
        tick();
        s_req_valid = 2'b00;
        checks++;
        if (m_req_valid !== 1'b1 || m_req_addr !== 12'h0BB) begin
            failures++; $display("FAIL ar_mreq got v=%b a=%h want 1/0bb", m_req_valid, m_req_addr);
        end
        tick();
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_resp_backpressure();
        test_req_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
